// File: rtl/csr_trap_seq_pkg.sv
// ----------------------------------------------------------------------------
// csr_trap_seq_pkg : shared CSR types, addresses and trap-sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package csr_trap_seq_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [31:0] word_t;

  localparam csr_addr_t CSR_MSTATUS = 12'h300;
  localparam csr_addr_t CSR_MTVEC   = 12'h305;
  localparam csr_addr_t CSR_MEPC    = 12'h341;
  localparam csr_addr_t CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam word_t IRQ_CAUSE_EXT = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T_EPC    = 3'd1,
    ST_T_CAUSE  = 3'd2,
    ST_T_STATUS = 3'd3,
    ST_T_VEC    = 3'd4,
    ST_R_STATUS = 3'd5,
    ST_R_EPC    = 3'd6
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_trap_seq.sv
// ----------------------------------------------------------------------------
// csr_trap_seq : owns the csr_file write port, runs trap/MRET CSR sequences
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module csr_trap_seq
  import csr_trap_seq_pkg::*;
#(
  parameter int    MIE_BIT   = MSTATUS_MIE,
  parameter int    MPIE_BIT  = MSTATUS_MPIE,
  parameter word_t IRQ_CAUSE = IRQ_CAUSE_EXT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        irq,
  input  logic [31:0] irq_pc,
  input  logic        mret_req,
  input  logic        ins_we,
  input  logic [11:0] ins_addr,
  input  logic [31:0] ins_wdata,
  output logic [31:0] ins_rdata,
  output logic        ins_stall,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_din,
  input  logic [31:0] csr_dout,
  input  logic [31:0] mstatus,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  word_t      r_pc;
  word_t      r_cause;
  word_t      r_last_pc;
  word_t      w_pc_nxt;
  word_t      w_cause_nxt;
  word_t      w_vec_pc;
  logic       w_take_irq;

  assign ins_rdata  = csr_dout;
  assign w_take_irq = irq & mstatus[MIE_BIT];
  assign w_vec_pc   = {csr_dout[31:2], 2'b00};

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cause_nxt    = r_cause;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_din        = '0;
    ins_stall      = 1'b1;
    redirect_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        csr_addr = ins_addr;
        csr_din  = ins_wdata;
        if (trap_req) begin
          w_state_nxt = ST_T_EPC;
          w_pc_nxt    = trap_pc;
          w_cause_nxt = trap_cause;
        end else if (w_take_irq) begin
          w_state_nxt = ST_T_EPC;
          w_pc_nxt    = irq_pc;
          w_cause_nxt = IRQ_CAUSE;
        end else if (mret_req) begin
          w_state_nxt = ST_R_STATUS;
        end else begin
          csr_we    = ins_we;
          ins_stall = 1'b0;
        end
      end
      ST_T_EPC: begin
        csr_we      = 1'b1;
        csr_addr    = CSR_MEPC;
        csr_din     = r_pc;
        w_state_nxt = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_we      = 1'b1;
        csr_addr    = CSR_MCAUSE;
        csr_din     = r_cause;
        w_state_nxt = ST_T_STATUS;
      end
      ST_T_STATUS: begin
        csr_we            = 1'b1;
        csr_addr          = CSR_MSTATUS;
        csr_din           = mstatus;
        csr_din[MPIE_BIT] = mstatus[MIE_BIT];
        csr_din[MIE_BIT]  = 1'b0;
        w_state_nxt       = ST_T_VEC;
      end
      ST_T_VEC: begin
        csr_addr       = CSR_MTVEC;
        redirect_valid = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_R_STATUS: begin
        csr_we            = 1'b1;
        csr_addr          = CSR_MSTATUS;
        csr_din           = mstatus;
        csr_din[MIE_BIT]  = mstatus[MPIE_BIT];
        csr_din[MPIE_BIT] = 1'b1;
        w_state_nxt       = ST_R_EPC;
      end
      ST_R_EPC: begin
        csr_addr       = CSR_MEPC;
        redirect_valid = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Reset squashes any in-flight write or redirect in the same cycle.
    if (rst) begin
      csr_we         = 1'b0;
      csr_addr       = '0;
      csr_din        = '0;
      ins_stall      = 1'b0;
      redirect_valid = 1'b0;
    end
  end

  assign redirect_pc = rst ? '0 : (redirect_valid ? w_vec_pc : r_last_pc);
  assign busy        = ~rst & (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_cause   <= '0;
      r_last_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cause <= w_cause_nxt;
      if (redirect_valid) begin
        r_last_pc <= w_vec_pc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_trap_seq.sv
// ----------------------------------------------------------------------------
// tb_csr_trap_seq : scoreboard bench for csr_trap_seq with a behavioural csr_file
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_csr_trap_seq;
  import csr_trap_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        irq = 1'b0;
  logic [31:0] irq_pc = '0;
  logic        mret_req = 1'b0;
  logic        ins_we = 1'b0;
  logic [11:0] ins_addr = '0;
  logic [31:0] ins_wdata = '0;
  logic [31:0] ins_rdata;
  logic        ins_stall;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_din;
  logic [31:0] csr_dout;
  logic [31:0] mstatus;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_trap_seq dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .irq(irq), .irq_pc(irq_pc), .mret_req(mret_req),
    .ins_we(ins_we), .ins_addr(ins_addr), .ins_wdata(ins_wdata),
    .ins_rdata(ins_rdata), .ins_stall(ins_stall),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_din(csr_din), .csr_dout(csr_dout),
    .mstatus(mstatus), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Behavioural csr_file: synchronous write, combinational read.
  logic [31:0] csr_mem [0:4095];
  logic        mem_init = 1'b1;
  assign csr_dout = csr_mem[csr_addr];
  assign mstatus  = csr_mem[CSR_MSTATUS];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= '0;
    end else if (csr_we) begin
      csr_mem[csr_addr] <= csr_din;
    end
  end

  typedef struct packed {
    logic        redir;
    logic [11:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        busy;
    logic        out;
    logic        rd_chk;
    logic [31:0] rdata;
    logic [31:0] rpc;
  } cyc_t;

  txn_t        sched[$];
  txn_t        exp_q[$];
  cyc_t        cyc_q[$];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] ref_last_pc = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each call is one clock cycle of stimulus plus its expectation.
  task automatic step(input logic r, input logic t, input logic [31:0] tc, input logic [31:0] tp,
                      input logic iq, input logic [31:0] ip, input logic mr,
                      input logic we, input logic [11:0] a, input logic [31:0] wd);
    cyc_t        c;
    txn_t        x;
    logic [31:0] ms;
    logic [31:0] nm;
    logic [31:0] pc;
    logic [31:0] cause;
    @(posedge clk);
    #1;
    rst = r; trap_req = t; trap_cause = tc; trap_pc = tp;
    irq = iq; irq_pc = ip; mret_req = mr;
    ins_we = we; ins_addr = a; ins_wdata = wd;
    c = '0;
    c.rst = r;
    if (r) begin
      sched.delete();
      ref_last_pc = '0;
    end else if (sched.size() > 0) begin
      x = sched.pop_front();
      c.stall = 1'b1;
      c.busy  = 1'b1;
      c.out   = 1'b1;
      exp_q.push_back(x);
      if (x.redir) ref_last_pc = x.data;
      else         ref_mem[x.addr] = x.data;
    end else begin
      ms = ref_mem[CSR_MSTATUS];
      if (t || (iq && ms[MSTATUS_MIE])) begin
        pc    = t ? tp : ip;
        cause = t ? tc : 32'h8000_000B;
        nm = ms;
        nm[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        nm[MSTATUS_MIE]  = 1'b0;
        sched.push_back('{1'b0, CSR_MEPC, pc});
        sched.push_back('{1'b0, CSR_MCAUSE, cause});
        sched.push_back('{1'b0, CSR_MSTATUS, nm});
        sched.push_back('{1'b1, CSR_MTVEC, ref_mem[CSR_MTVEC] & ~32'd3});
        c.stall = 1'b1;
      end else if (mr) begin
        nm = ms;
        nm[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        nm[MSTATUS_MPIE] = 1'b1;
        sched.push_back('{1'b0, CSR_MSTATUS, nm});
        sched.push_back('{1'b1, CSR_MEPC, ref_mem[CSR_MEPC] & ~32'd3});
        c.stall = 1'b1;
      end else begin
        c.rd_chk = 1'b1;
        c.rdata  = ref_mem[a];
        if (we) begin
          c.out = 1'b1;
          exp_q.push_back('{1'b0, a, wd});
          ref_mem[a] = wd;
        end
      end
    end
    c.rpc = ref_last_pc;
    cyc_q.push_back(c);
  endtask

  task automatic idle(input logic [11:0] a);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(0, 0, 0, 0, 0, 0, 0, 1, a, d);
  endtask

  // Monitor: compares every cycle's handshake and pops one transaction per DUT output.
  cyc_t mc;
  txn_t mx;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("ins_stall", {31'd0, ins_stall}, {31'd0, mc.stall});
      chk("busy", {31'd0, busy}, {31'd0, mc.busy});
      chk("redirect_pc", redirect_pc, mc.rpc);
      if (mc.rd_chk) chk("ins_rdata", ins_rdata, mc.rdata);
      chk("output_present", {31'd0, csr_we | redirect_valid}, {31'd0, mc.out});
      if (mc.out && (csr_we || redirect_valid)) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          mx = exp_q.pop_front();
          chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mx.redir});
          chk("csr_we", {31'd0, csr_we}, {31'd0, ~mx.redir});
          chk("csr_addr", {20'd0, csr_addr}, {20'd0, mx.addr});
          if (!mx.redir) chk("csr_din", csr_din, mx.data);
          else           chk("redirect_target", redirect_pc, mx.data);
        end
      end
    end
  end

  localparam logic [11:0] ADDRS [0:4] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_init = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // mtvec write and read-back, then enable MIE
    wr(CSR_MTVEC, 32'h100);
    idle(CSR_MTVEC);
    wr(CSR_MSTATUS, 32'h8);

    // Trap; an instruction write during busy must be stalled and dropped
    step(0, 1, 32'd2, 32'h40, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1, CSR_MCAUSE, 32'hDEAD);
    idle(CSR_MCAUSE);

    // MRET restores MIE from MPIE
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0); idle(0);
    idle(CSR_MSTATUS);

    // Interrupt taken, then masked by MIE=0 while irq stays high
    step(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 32'h80, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80, 0, 0, CSR_MCAUSE, 0);
    step(0, 0, 0, 0, 1, 32'h80, 0, 0, CSR_MEPC, 0);
    wr(CSR_MSTATUS, 32'h0);
    step(0, 0, 0, 0, 1, 32'h84, 0, 0, CSR_MSTATUS, 0);

    // Trap and MRET together: trap wins
    wr(CSR_MSTATUS, 32'h8);
    step(0, 1, 32'd5, 32'h44, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(0);

    // Reset during T_CAUSE aborts the sequence
    wr(CSR_MSTATUS, 32'h8);
    step(0, 1, 32'd7, 32'h60, 0, 0, 0, 0, 0, 0);
    idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(CSR_MCAUSE);
    idle(CSR_MSTATUS);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) == 0, $urandom, $urandom,
           $urandom_range(0, 6) == 0, $urandom,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, ADDRS[$urandom_range(0, 4)], $urandom);
    end

    for (int i = 0; i < 8; i++) idle(0);
    @(negedge clk);
    @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    chk("leftover_cycles", cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
